// File: rtl/mpsoc_onchip_mem_dual_arb.sv
// Dual-port Avalon-MM front end on a single-port RAM: round-robin arbitration,
// byte-enabled writes, pipelined reads with optional output register.
module mpsoc_onchip_mem_dual_arb #(
  parameter int    DATA_WIDTH = 32,
  parameter int    ADDR_WIDTH = 14,
  parameter int    DEPTH      = 16384,
  parameter bit    OUTREG     = 1'b0,
  parameter string INIT_FILE  = "MPSoC_onchip_mem0.hex"
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clken,

  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic                    s1_waitrequest,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,

  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic                    s2_waitrequest,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic { PORT_S1 = 1'b0, PORT_S2 = 1'b1 } port_e;

  // Preloading from INIT_FILE belongs to the configuration image flow, not to run-time logic.
  if (INIT_FILE != "") begin : g_init_image
  end

  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

  port_e                 r_rr_last;
  logic                  r_p1_vld;
  port_e                 r_p1_port;
  logic [DATA_WIDTH-1:0] r_p1_data;
  logic                  r_s1_rvld;
  logic                  r_s2_rvld;
  logic [DATA_WIDTH-1:0] r_s1_rdata;
  logic [DATA_WIDTH-1:0] r_s2_rdata;

  logic                  w_en;
  logic                  w_req1;
  logic                  w_req2;
  logic                  w_grant1;
  logic                  w_grant2;
  logic                  w_acc;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [BE_W-1:0]       w_be;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  w_wr;
  logic                  w_in_range;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_wr_fire;
  logic                  w_rd_fire;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic                  w_o_vld;
  port_e                 w_o_port;
  logic [DATA_WIDTH-1:0] w_o_data;

  assign w_en   = clken & ~reset;
  assign w_req1 = s1_chipselect & (s1_read | s1_write);
  assign w_req2 = s2_chipselect & (s2_read | s2_write);

  // On conflict the port that did not win last time gets the slot.
  assign w_grant1 = w_en & w_req1 & (~w_req2 | (r_rr_last == PORT_S2));
  assign w_grant2 = w_en & w_req2 & (~w_req1 | (r_rr_last == PORT_S1));
  assign w_acc    = w_grant1 | w_grant2;

  assign s1_waitrequest = w_req1 & ~w_grant1;
  assign s2_waitrequest = w_req2 & ~w_grant2;

  assign w_addr     = w_grant2 ? s2_address    : s1_address;
  assign w_be       = w_grant2 ? s2_byteenable : s1_byteenable;
  assign w_wdata    = w_grant2 ? s2_writedata  : s1_writedata;
  assign w_wr       = w_grant2 ? s2_write      : s1_write;
  assign w_in_range = {1'b0, w_addr} < DEPTH_L;
  assign w_idx      = w_addr[IDX_W-1:0];

  assign w_wr_fire = w_acc & w_wr & w_in_range;
  assign w_rd_fire = w_acc & ~w_wr;
  assign w_rd_word = w_in_range ? r_mem[w_idx] : '0;

  // NOTE: the storage array has no reset; contents must survive a reset pulse
  // and a resettable array cannot map onto block RAM.
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      for (int b = 0; b < BE_W; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clken && w_rd_fire) r_p1_data <= w_rd_word;
  end

  assign w_o_vld  = OUTREG ? r_p1_vld  : w_rd_fire;
  assign w_o_port = OUTREG ? r_p1_port : (w_grant2 ? PORT_S2 : PORT_S1);
  assign w_o_data = OUTREG ? r_p1_data : w_rd_word;

  // NOTE: non-blocking assignments throughout so every register samples the
  // pre-edge value of its sources regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_last  <= PORT_S2;
      r_p1_vld   <= 1'b0;
      r_p1_port  <= PORT_S1;
      r_s1_rvld  <= 1'b0;
      r_s2_rvld  <= 1'b0;
      r_s1_rdata <= '0;
      r_s2_rdata <= '0;
    end else if (clken) begin
      if (w_acc) r_rr_last <= w_grant2 ? PORT_S2 : PORT_S1;
      r_p1_vld  <= w_rd_fire;
      r_p1_port <= w_grant2 ? PORT_S2 : PORT_S1;
      r_s1_rvld <= w_o_vld & (w_o_port == PORT_S1);
      r_s2_rvld <= w_o_vld & (w_o_port == PORT_S2);
      if (w_o_vld && w_o_port == PORT_S1) r_s1_rdata <= w_o_data;
      if (w_o_vld && w_o_port == PORT_S2) r_s2_rdata <= w_o_data;
    end
  end

  // A frozen or resetting pipeline must not present a pulse the master would count.
  assign s1_readdatavalid = r_s1_rvld & clken & ~reset;
  assign s2_readdatavalid = r_s2_rvld & clken & ~reset;
  assign s1_readdata      = r_s1_rdata;
  assign s2_readdata      = r_s2_rdata;

endmodule

// File: tb/tb_mpsoc_onchip_mem_dual_arb.sv
// Directed bench: one vector table on the latency-1 instance, plus hand sequences
// for the latency-2 instance, clock-enable freeze and reset mid-read.
module tb_mpsoc_onchip_mem_dual_arb;

  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int DEPTH = 200;

  logic clk = 1'b0;
  logic reset, clken;
  logic [AW-1:0] s1_address, s2_address;
  logic [3:0]    s1_byteenable, s2_byteenable;
  logic          s1_chipselect, s1_read, s1_write;
  logic          s2_chipselect, s2_read, s2_write;
  logic [DW-1:0] s1_writedata, s2_writedata;

  logic          a_s1_wait, a_s1_rv, a_s2_wait, a_s2_rv;
  logic [DW-1:0] a_s1_rd, a_s2_rd;
  logic          b_s1_wait, b_s1_rv, b_s2_wait, b_s2_rv;
  logic [DW-1:0] b_s1_rd, b_s2_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mpsoc_onchip_mem_dual_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
                              .OUTREG(1'b0), .INIT_FILE("")) u_dut0 (
    .clk(clk), .reset(reset), .clken(clken),
    .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_chipselect(s1_chipselect),
    .s1_read(s1_read), .s1_write(s1_write), .s1_writedata(s1_writedata),
    .s1_waitrequest(a_s1_wait), .s1_readdata(a_s1_rd), .s1_readdatavalid(a_s1_rv),
    .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_chipselect(s2_chipselect),
    .s2_read(s2_read), .s2_write(s2_write), .s2_writedata(s2_writedata),
    .s2_waitrequest(a_s2_wait), .s2_readdata(a_s2_rd), .s2_readdatavalid(a_s2_rv)
  );

  mpsoc_onchip_mem_dual_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
                              .OUTREG(1'b1), .INIT_FILE("")) u_dut1 (
    .clk(clk), .reset(reset), .clken(clken),
    .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_chipselect(s1_chipselect),
    .s1_read(s1_read), .s1_write(s1_write), .s1_writedata(s1_writedata),
    .s1_waitrequest(b_s1_wait), .s1_readdata(b_s1_rd), .s1_readdatavalid(b_s1_rv),
    .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_chipselect(s2_chipselect),
    .s2_read(s2_read), .s2_write(s2_write), .s2_writedata(s2_writedata),
    .s2_waitrequest(b_s2_wait), .s2_readdata(b_s2_rd), .s2_readdatavalid(b_s2_rv)
  );

  typedef struct {
    logic          cs, rd, wr;
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic [DW-1:0] wd;
  } req_t;

  typedef struct {
    logic          rst, ce;
    req_t          r1, r2;
    logic          w1, w2, v1, v2;
    logic [DW-1:0] d1, d2;
  } vec_t;

  vec_t vecs[$];

  function automatic req_t idle();
    return '{1'b0, 1'b0, 1'b0, '0, '0, '0};
  endfunction

  function automatic req_t rq(input logic [AW-1:0] a);
    return '{1'b1, 1'b1, 1'b0, a, 4'hF, '0};
  endfunction

  function automatic req_t wq(input logic [AW-1:0] a, input logic [3:0] be, input logic [DW-1:0] d);
    return '{1'b1, 1'b0, 1'b1, a, be, d};
  endfunction

  task automatic v(input logic rst, input logic ce, input req_t r1, input req_t r2,
                   input logic w1, input logic w2, input logic v1, input logic [DW-1:0] d1,
                   input logic v2, input logic [DW-1:0] d2);
    vec_t t;
    t.rst = rst; t.ce = ce; t.r1 = r1; t.r2 = r2;
    t.w1 = w1; t.w2 = w2; t.v1 = v1; t.v2 = v2; t.d1 = d1; t.d2 = d2;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs and let combinational outputs settle.
  task automatic cyc(input logic rst, input logic ce, input req_t r1, input req_t r2);
    reset = rst; clken = ce;
    s1_chipselect = r1.cs; s1_read = r1.rd; s1_write = r1.wr;
    s1_address = r1.addr; s1_byteenable = r1.be; s1_writedata = r1.wd;
    s2_chipselect = r2.cs; s2_read = r2.rd; s2_write = r2.wr;
    s2_address = r2.addr; s2_byteenable = r2.be; s2_writedata = r2.wd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [AW-1:0] sa [4];
    logic [DW-1:0] sd [4];
    logic          ev;
    logic [DW-1:0] ed;

    // rst ce  s1                           s2                           w1 w2 v1 d1            v2 d2
    v(1, 1, rq(8'h10),                   rq(8'h10),                   1, 1, 0, 0,            0, 0);
    v(1, 1, idle(),                      idle(),                      0, 0, 0, 0,            0, 0);
    v(0, 1, wq(8'h10, 4'hF, 32'hDEADBEEF), idle(),                    0, 0, 0, 0,            0, 0);
    v(0, 1, idle(),                      rq(8'h10),                   0, 0, 0, 0,            0, 0);
    v(0, 1, idle(),                      idle(),                      0, 0, 0, 0,            1, 32'hDEADBEEF);
    v(0, 1, wq(8'h20, 4'hF, 32'h11223344), idle(),                    0, 0, 0, 0,            0, 0);
    v(0, 1, wq(8'h20, 4'h5, 32'hAABBCCDD), idle(),                    0, 0, 0, 0,            0, 0);
    v(0, 1, rq(8'h20),                   idle(),                      0, 0, 0, 0,            0, 0);
    v(0, 1, idle(),                      idle(),                      0, 0, 1, 32'h11BB33DD, 0, 0);
    // Simultaneous writes: s1 won last, so s2 goes first, then alternate.
    v(0, 1, wq(8'h30, 4'hF, 32'hA0000030), wq(8'h40, 4'hF, 32'hB0000040), 1, 0, 0, 0,      0, 0);
    v(0, 1, wq(8'h30, 4'hF, 32'hA0000030), wq(8'h41, 4'hF, 32'hB0000041), 0, 1, 0, 0,      0, 0);
    v(0, 1, wq(8'h31, 4'hF, 32'hA0000031), wq(8'h41, 4'hF, 32'hB0000041), 1, 0, 0, 0,      0, 0);
    v(0, 1, wq(8'h31, 4'hF, 32'hA0000031), wq(8'h42, 4'hF, 32'hB0000042), 0, 1, 0, 0,      0, 0);
    v(0, 1, wq(8'h32, 4'hF, 32'hA0000032), wq(8'h42, 4'hF, 32'hB0000042), 1, 0, 0, 0,      0, 0);
    v(0, 1, wq(8'h32, 4'hF, 32'hA0000032), idle(),                    0, 0, 0, 0,            0, 0);
    v(1, 1, idle(),                      idle(),                      0, 0, 0, 0,            0, 0);
    // Continuous reads from both ports after reset: s1 first, then alternate.
    v(0, 1, rq(8'h30),                   rq(8'h40),                   0, 1, 0, 0,            0, 0);
    v(0, 1, rq(8'h31),                   rq(8'h40),                   1, 0, 1, 32'hA0000030, 0, 0);
    v(0, 1, rq(8'h31),                   rq(8'h41),                   0, 1, 0, 0,            1, 32'hB0000040);
    v(0, 1, rq(8'h32),                   rq(8'h41),                   1, 0, 1, 32'hA0000031, 0, 0);
    v(0, 1, rq(8'h32),                   rq(8'h42),                   0, 1, 0, 0,            1, 32'hB0000041);
    v(0, 1, idle(),                      rq(8'h42),                   0, 0, 1, 32'hA0000032, 0, 0);
    v(0, 1, idle(),                      idle(),                      0, 0, 0, 0,            1, 32'hB0000042);
    // Out of range: write dropped, read returns zero on time.
    v(0, 1, wq(8'hD0, 4'hF, 32'h12345678), idle(),                    0, 0, 0, 0,            0, 0);
    v(0, 1, rq(8'hD0),                   idle(),                      0, 0, 0, 0,            0, 0);
    v(0, 1, idle(),                      idle(),                      0, 0, 1, 32'h0,        0, 0);
    // Read and write together is a write with no response.
    v(0, 1, idle(),                      '{1'b1, 1'b1, 1'b1, 8'h50, 4'hF, 32'h55555555}, 0, 0, 0, 0, 0, 0);
    v(0, 1, idle(),                      idle(),                      0, 0, 0, 0,            0, 0);
    v(0, 1, idle(),                      rq(8'h50),                   0, 0, 0, 0,            0, 0);
    v(0, 1, idle(),                      idle(),                      0, 0, 0, 0,            1, 32'h55555555);
    // Read without chipselect is not a request.
    v(0, 1, '{1'b0, 1'b1, 1'b0, 8'h10, 4'hF, '0}, idle(),            0, 0, 0, 0,            0, 0);
    v(0, 1, idle(),                      idle(),                      0, 0, 0, 0,            0, 0);
    v(0, 1, idle(),                      idle(),                      0, 0, 0, 0,            0, 0);

    cyc(1'b1, 1'b1, idle(), idle());
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].rst, vecs[i].ce, vecs[i].r1, vecs[i].r2);
      check($sformatf("v%0d s1_wait", i), 32'(a_s1_wait), 32'(vecs[i].w1));
      check($sformatf("v%0d s2_wait", i), 32'(a_s2_wait), 32'(vecs[i].w2));
      check($sformatf("v%0d s1_rvld", i), 32'(a_s1_rv),   32'(vecs[i].v1));
      check($sformatf("v%0d s2_rvld", i), 32'(a_s2_rv),   32'(vecs[i].v2));
      if (vecs[i].v1) check($sformatf("v%0d s1_rdata", i), a_s1_rd, vecs[i].d1);
      if (vecs[i].v2) check($sformatf("v%0d s2_rdata", i), a_s2_rd, vecs[i].d2);
      tick();
    end

    // Four back-to-back reads on s1: latency 1 on dut0, latency 2 on dut1, no gaps.
    sa[0] = 8'h30; sa[1] = 8'h31; sa[2] = 8'h32; sa[3] = 8'h40;
    sd[0] = 32'hA0000030; sd[1] = 32'hA0000031; sd[2] = 32'hA0000032; sd[3] = 32'hB0000040;
    for (int c = 0; c < 7; c++) begin
      cyc(1'b0, 1'b1, (c < 4) ? rq(sa[c]) : idle(), idle());
      if (c < 4) check($sformatf("burst c%0d s1_wait", c), 32'(a_s1_wait), 32'd0);
      ev = (c >= 1 && c <= 4);
      check($sformatf("burst c%0d l1 rvld", c), 32'(a_s1_rv), 32'(ev));
      if (ev) check($sformatf("burst c%0d l1 rdata", c), a_s1_rd, sd[c-1]);
      ev = (c >= 2 && c <= 5);
      check($sformatf("burst c%0d l2 rvld", c), 32'(b_s1_rv), 32'(ev));
      if (ev) check($sformatf("burst c%0d l2 rdata", c), b_s1_rd, sd[c-2]);
      tick();
    end

    // Clock enable dropped for three cycles right after a read is accepted.
    ed = 32'h11BB33DD;
    cyc(1'b0, 1'b1, rq(8'h20), idle());
    check("ce accept s1_wait", 32'(a_s1_wait), 32'd0);
    tick();
    for (int c = 0; c < 3; c++) begin
      cyc(1'b0, 1'b0, idle(), rq(8'h10));
      check($sformatf("ce low %0d s2_wait", c), 32'(a_s2_wait), 32'd1);
      check($sformatf("ce low %0d l1 rvld", c), 32'(a_s1_rv), 32'd0);
      check($sformatf("ce low %0d l2 rvld", c), 32'(b_s1_rv), 32'd0);
      check($sformatf("ce low %0d l1 s2_rvld", c), 32'(a_s2_rv), 32'd0);
      tick();
    end
    cyc(1'b0, 1'b1, idle(), idle());
    check("ce back l1 rvld", 32'(a_s1_rv), 32'd1);
    check("ce back l1 rdata", a_s1_rd, ed);
    check("ce back l2 rvld early", 32'(b_s1_rv), 32'd0);
    tick();
    cyc(1'b0, 1'b1, idle(), idle());
    check("ce back+1 l1 rvld once", 32'(a_s1_rv), 32'd0);
    check("ce back+1 l2 rvld", 32'(b_s1_rv), 32'd1);
    check("ce back+1 l2 rdata", b_s1_rd, ed);
    tick();
    cyc(1'b0, 1'b1, idle(), idle());
    check("ce back+2 l2 rvld once", 32'(b_s1_rv), 32'd0);
    tick();

    // Reset right after a read is accepted: response flushed, array kept, s1 wins next conflict.
    cyc(1'b0, 1'b1, rq(8'h31), idle());
    check("rst accept s1_wait", 32'(a_s1_wait), 32'd0);
    tick();
    cyc(1'b1, 1'b1, idle(), rq(8'h40));
    check("rst s2_wait", 32'(a_s2_wait), 32'd1);
    check("rst l1 rvld", 32'(a_s1_rv), 32'd0);
    check("rst l2 rvld", 32'(b_s1_rv), 32'd0);
    tick();
    cyc(1'b0, 1'b1, idle(), idle());
    check("post rst l1 rvld", 32'(a_s1_rv), 32'd0);
    check("post rst l2 rvld", 32'(b_s1_rv), 32'd0);
    check("post rst l1 rdata", a_s1_rd, 32'h0);
    check("post rst l2 rdata", b_s1_rd, 32'h0);
    tick();
    cyc(1'b0, 1'b1, rq(8'h31), rq(8'h41));
    check("post rst conflict s1_wait", 32'(a_s1_wait), 32'd0);
    check("post rst conflict s2_wait", 32'(a_s2_wait), 32'd1);
    tick();
    cyc(1'b0, 1'b1, idle(), rq(8'h41));
    check("post rst s2 turn s2_wait", 32'(a_s2_wait), 32'd0);
    check("post rst l1 rvld data", 32'(a_s1_rv), 32'd1);
    check("post rst l1 rdata kept", a_s1_rd, 32'hA0000031);
    tick();
    cyc(1'b0, 1'b1, idle(), idle());
    check("post rst l1 s2_rvld", 32'(a_s2_rv), 32'd1);
    check("post rst l1 s2_rdata", a_s2_rd, 32'hB0000041);
    check("post rst l2 s1_rvld", 32'(b_s1_rv), 32'd1);
    check("post rst l2 s1_rdata", b_s1_rd, 32'hA0000031);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mpsoc_onchip_mem_dual_arb.md
Name: mpsoc_onchip_mem_dual_arb

Overview:
Parametrised on-chip RAM with two Avalon-MM pipelined slave ports (s1, s2) sharing one single-port storage array.
- Round-robin arbiter grants one access per clock; the losing port sees waitrequest.
- Supports byte-enabled writes, pipelined reads with readdatavalid, and a selectable output register (read latency 1 or 2).
- Drop-in for processor instruction/data memory where two masters share one block.

Parameters:
DATA_WIDTH, 32, data word width; must be a multiple of 8.
ADDR_WIDTH, 14, word address width per port.
DEPTH, 16384, number of words; DEPTH <= 2**ADDR_WIDTH.
OUTREG, 0, 0 = read latency 1; 1 = extra output register, read latency 2.
INIT_FILE, "MPSoC_onchip_mem0.hex", initial contents; loaded at configuration only.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
clken  in  1  global clock enable
sN_address  in  ADDR_WIDTH  word address (N = 1, 2)
sN_byteenable  in  DATA_WIDTH/8  byte lanes for writes
sN_chipselect  in  1  port select
sN_read  in  1  read request
sN_write  in  1  write request
sN_writedata  in  DATA_WIDTH  write data
sN_waitrequest  out  1  request not accepted this cycle; master holds all signals
sN_readdata  out  DATA_WIDTH  read data, valid when sN_readdatavalid=1
sN_readdatavalid  out  1  one-cycle pulse per accepted read

Behaviour:
- reqN = sN_chipselect & (sN_read | sN_write). If sN_read and sN_write are both high, the access is a write and produces no readdatavalid.
- Grant is combinational from reqN, rr_last and clken. An access is accepted at the rising edge where grantN=1 and reset=0.
- Arbitration:
  - Only one port requesting: that port is granted.
  - Both requesting: the port not equal to rr_last is granted. rr_last updates to the winner on each accepted access.
  - sN_waitrequest = reqN & ~grantN. It is 0 when idle.
- Write: on acceptance, bytes with byteenable=1 are updated and others kept. A later access from either port sees the new data.
- Read:
  - Array is read at the acceptance edge.
  - OUTREG=0: readdata/readdatavalid appear the cycle after acceptance.
  - OUTREG=1: they appear two cycles after acceptance.
  - Back-to-back reads are fully pipelined: one result per cycle. Per-port responses stay in request order.
- Out of range (address >= DEPTH): writes are dropped; reads return 0 with normal readdatavalid timing.
- clken=0:
  - No grants: requesting ports see waitrequest=1.
  - Read pipeline frozen; readdatavalid forced 0.
  - Pending results emerge when clken returns, each exactly once.
- Reset (any cycle, including mid-read):
  - rr_last := s2, so s1 wins the first conflict.
  - Read pipeline flushed: in-flight reads produce no readdatavalid.
  - readdata := 0, readdatavalid := 0.
  - While reset=1, all requests see waitrequest=1.
  - Array contents are NOT cleared.
- readdata holds its last value between valid pulses.

Test Plan:
- s1 write addr 0x10 data 0xDEADBEEF be=1111, then s2 read 0x10 → s2_readdatavalid pulses 1 cycle after acceptance (OUTREG=0) with 0xDEADBEEF.
- s1 write 0x20 = 0x11223344, then s1 write 0x20 = 0xAABBCCDD be=0101, read 0x20 → 0x11BB33DD.
- Both ports read continuously for 6 cycles after reset → grants alternate s1,s2,s1,…; each port waits every other cycle; 3 valid pulses per port, data in order.
- OUTREG=1, s1 issues reads at 4 consecutive addresses → 4 consecutive readdatavalid pulses starting 2 cycles after the first acceptance, no gaps.
- Read accepted, then clken=0 for 3 cycles → no readdatavalid while low; exactly one pulse with correct data after clken returns; s2 request during clken=0 sees waitrequest=1.
- Read accepted, reset asserted next cycle → no readdatavalid; prior write data still readable after reset; first simultaneous request after reset is granted to s1.
